// File: rtl/output_drain.sv
// Drain stage: gathers rows x cols result tile from the array, then streams it element by element.
// Latency: first element valid the cycle after the last row is captured; one element per accepted beat.
// Backpressure: in_ready low while draining (rows dropped + drop_err); out held stable while out_ready low.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   flush           synchronous abort of the current tile, back to FILL
//   in_valid/in_ready/outs_array   row input from the array (col c at [(c+1)*width-1:c*width])
//   out/out_valid/out_ready/out_last/rd_addr   element stream to the sink, row-major
//   drop_err        sticky flag: a row arrived while not accepting
module output_drain #(
  parameter int width = 8,
  parameter int rows  = 4,
  parameter int cols  = 4,
  localparam int AW   = (rows * cols > 1) ? $clog2(rows * cols) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [cols*width-1:0] outs_array,
  output logic [width-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [AW-1:0]         rd_addr,
  output logic                  drop_err
);

  localparam int RW = (rows > 1) ? $clog2(rows) : 1;
  localparam int CW = (cols > 1) ? $clog2(cols) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [RW-1:0]    wr_row;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic [AW-1:0]    rd_idx;
  logic [width-1:0] store [rows][cols];

  logic wr_last, rd_last, in_fire, out_fire;

  assign wr_last  = (wr_row == RW'(rows - 1));
  assign rd_last  = (rd_idx == AW'(rows * cols - 1));
  assign in_fire  = in_valid  && (state == FILL);
  assign out_fire = out_ready && (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_fire && wr_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && rd_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    if (flush) state_nxt = FILL;
  end

  // rd_row/rd_col walk alongside rd_idx so the store read needs no divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_row <= '0;
      rd_row <= '0;
      rd_col <= '0;
      rd_idx <= '0;
      for (int r = 0; r < rows; r++)
        for (int c = 0; c < cols; c++)
          store[r][c] <= '0;
    end else if (flush) begin
      wr_row <= '0;
      rd_row <= '0;
      rd_col <= '0;
      rd_idx <= '0;
    end else begin
      if (in_fire) begin
        for (int c = 0; c < cols; c++)
          store[wr_row][c] <= outs_array[c*width +: width];
        wr_row <= wr_last ? '0 : wr_row + RW'(1);
      end
      if (out_fire) begin
        if (rd_last) begin
          rd_row <= '0;
          rd_col <= '0;
          rd_idx <= '0;
        end else begin
          rd_idx <= rd_idx + AW'(1);
          if (rd_col == CW'(cols - 1)) begin
            rd_col <= '0;
            rd_row <= rd_row + RW'(1);
          end else begin
            rd_col <= rd_col + CW'(1);
          end
        end
      end
    end
  end

  // Rows offered while draining are lost; remember that until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              drop_err <= 1'b0;
    else if (in_valid && (state == DRAIN)) drop_err <= 1'b1;
  end

  // Outputs depend only on registered state, never on out_ready.
  assign out      = (state == DRAIN) ? store[rd_row][rd_col] : '0;
  assign out_last = (state == DRAIN) && rd_last;
  assign rd_addr  = (state == DRAIN) ? rd_idx : '0;

endmodule
